// File: rtl/muldiv_iter_if.sv
// Handshake/result bundle between the EX-stage controller (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             stallreq;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output flush, start, op, src_a, src_b,
        input  busy, stallreq, done, hi, lo, div_by_zero
    );

    modport slave (
        input  flush, start, op, src_a, src_b,
        output busy, stallreq, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sign-corrected into a registered HI/LO pair.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_iter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Absolute value taken one bit wider so that -2^(WIDTH-1) maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        logic [WIDTH:0] ext;
        ext = {is_signed & v[WIDTH-1], v};
        ext = ext[WIDTH] ? -ext : ext;
        return ext[WIDTH-1:0];
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               sign_pq_q, sign_pq_d;
    logic               sign_r_q, sign_r_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_rem_s;
    logic [WIDTH:0]     div_diff_s;
    logic               div_ge_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic               op_div_s;
    logic               op_signed_s;

    assign op_div_s    = bus.op[1];
    assign op_signed_s = ~bus.op[0];

    // One iteration of each algorithm and the sign-corrected final results.
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
        div_rem_s  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s = div_rem_s - {1'b0, b_q};
        div_ge_s   = ~div_diff_s[WIDTH];
        div_next_s = {(div_ge_s ? div_diff_s[WIDTH-1:0] : div_rem_s[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ge_s};
        prod_s     = sign_pq_q ? -acc_q : acc_q;
        quot_s     = sign_pq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_s      = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state logic; flush overrides everything and leaves hi/lo untouched.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        sign_pq_d = sign_pq_q;
        sign_r_d  = sign_r_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && op_div_s && (bus.src_b == '0)) begin
                        hi_d    = bus.src_a;
                        lo_d    = '1;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (bus.start) begin
                        is_div_d  = op_div_s;
                        sign_pq_d = op_signed_s & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                        sign_r_d  = op_signed_s & op_div_s & bus.src_a[WIDTH-1];
                        acc_d     = {{WIDTH{1'b0}}, magnitude(bus.src_a, op_signed_s)};
                        b_d       = magnitude(bus.src_b, op_signed_s);
                        cnt_d     = '0;
                        state_d   = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        if (is_div_q) begin
                            hi_d = rem_s;
                            lo_d = quot_s;
                        end else begin
                            hi_d = prod_s[2*WIDTH-1:WIDTH];
                            lo_d = prod_s[WIDTH-1:0];
                        end
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        acc_d = is_div_q ? div_next_s : mul_next_s;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            sign_pq_q <= 1'b0;
            sign_r_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            sign_pq_q <= sign_pq_d;
            sign_r_q  <= sign_r_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            dbz_q     <= dbz_d;
        end
    end

    // stallreq drops in DONE so the owning instruction advances with the result.
    assign bus.stallreq    = ~rst & ~bus.flush
                           & (((state_q == S_IDLE) & bus.start) | (state_q == S_RUN));
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage; it replaces single-cycle HI/LO arithmetic.
- Executes MULT/MULTU/DIV/DIVU over WIDTH cycles using shift-add (multiply) and restoring shift-subtract (divide).
- Raises a stall request to the pipeline controller while busy.
- Delivers a HI/LO result pair, with a one-cycle completion pulse, for the HI/LO write path.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.
- CNT_W, 6: counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  cancel any in-flight operation (exception or branch kill).
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  input  WIDTH  multiplicand or dividend.
- src_b  input  WIDTH  multiplier or divisor.
- busy  output  1  high in RUN and DONE.
- stallreq  output  1  stall request to the controller.
- done  output  1  one-cycle pulse; result valid this cycle.
- hi  output  WIDTH  product high half, or remainder.
- lo  output  WIDTH  product low half, or quotient.
- div_by_zero  output  1  high together with done when a DIV/DIVU had src_b == 0.

Behaviour:
- Reset (async, rst = 1): state = IDLE; hi = 0, lo = 0, done = 0, busy = 0, stallreq = 0, div_by_zero = 0; counter and internal registers = 0. Reset mid-operation abandons it immediately.
- States are IDLE, RUN, DONE.
- IDLE + start + !flush:
  - Latch op and the operand magnitudes.
  - Signed ops (MULT, DIV): magnitude = two's-complement absolute value, computed in WIDTH+1 bits so that -2^(WIDTH-1) is handled.
  - Record the result signs: product/quotient negative iff the operand signs differ; remainder takes the dividend's sign.
  - Counter = 0. Go to RUN.
- IDLE + start + divide with src_b == 0: go directly to DONE. Result: lo = all ones, hi = src_a, div_by_zero = 1.
- RUN: one iteration per cycle; counter increments; after WIDTH iterations go to DONE.
  - Multiply: 2*WIDTH-bit accumulator, shift-add on the low multiplier bit.
  - Divide: restoring algorithm, one quotient bit per cycle (MSB first).
- DONE (exactly one cycle):
  - Apply sign correction. Outputs are truncated to WIDTH bits.
  - Overflow case DIV -2^(WIDTH-1) / -1 yields lo = 0x80000000, hi = 0 for WIDTH = 32.
  - Register hi/lo; done = 1.
  - Next state is IDLE.
- Latency: start accepted at edge 0 → done high in the cycle after edge WIDTH+1 (33 cycles for WIDTH = 32). Divide-by-zero: done after 1 edge.
- stallreq = (state == IDLE && start && !flush) || state == RUN. stallreq is low in DONE, so the instruction advances while the result is valid.
- hi/lo hold the last completed result until the next DONE; they never show partial values.
- start while busy: ignored, with no queueing.
- flush has priority over start and over all states: the next state is IDLE, no done pulse, hi/lo unchanged, stallreq low in the same cycle.
- flush in DONE: done is still asserted that cycle; hi/lo still update; the next state is IDLE.
- div_by_zero is cleared on every other DONE and held low otherwise.

Test Plan:
- MULTU 0xFFFFFFFF × 0x00000002 → hi = 0x00000001, lo = 0xFFFFFFFE. done pulses exactly 33 cycles after start. stallreq high for 33 cycles, then low.
- MULT 0xFFFFFFFD (-3) × 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 100 / 7 → lo = 14, hi = 2. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 0x1234 / 0 → done after 1 cycle, div_by_zero = 1, lo = 0xFFFFFFFF, hi = 0x1234.
- Abort and retry:
  - Start DIVU, flush at cycle 10 → no done; hi/lo keep their prior values; stallreq drops the same cycle.
  - A new start the following cycle completes normally.
  - A second start held during RUN is ignored.
- Async reset asserted mid-RUN (between edges) → all outputs 0 immediately.
- Rerun with WIDTH = 8, CNT_W = 4: MULTU 0xFF × 0xFF → hi = 0xFE, lo = 0x01, done 9 cycles after start.
